mul_frag_scheduler: RTL and testbench

- Packs a stream of independent multiply requests of 9-, 4- or 2-bit precision into one shared fragmentable 9x9 multiplier.
- Issues each batch as one multiplier operation: 1x 9x9, 2x 4x4 or 4x 2x2.
- Drives the multiplier's operand, sign and HALF_0/1/2 mode inputs from registers, then returns the packed product with a lane mask.
- Sits between request producers and the combinational multiplier in the fragmentable-DSP datapath.

---
 rtl/mul_frag_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_mul_frag_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_frag_scheduler.sv
// rtl/mul_frag_scheduler.sv - packs 9/4/2-bit multiply requests into batches for one fragmentable 9x9 multiplier
// Optional macro MUL_SCHED_PERF_EN adds perf_batches/perf_lanes counters.
module mul_frag_scheduler #(
  parameter int TAG_W         = 4,
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic               in_signed,
  input  logic [8:0]         in_a,
  input  logic [8:0]         in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [8:0]         mul_A,
  output logic [8:0]         mul_B,
  output logic               mul_A_sign,
  output logic               mul_B_sign,
  output logic               mul_HALF_0,
  output logic               mul_HALF_1,
  output logic               mul_HALF_2,
  input  logic [17:0]        mul_C,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_mode,
  output logic               out_signed,
  output logic [3:0]         out_lane_mask,
  output logic [17:0]        out_c,
  output logic [4*TAG_W-1:0] out_tags,
  output logic               err_illegal
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_batches,
  output logic [31:0]        perf_lanes
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ISSUE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [15:0] LP_FLUSH = 16'(FLUSH_TIMEOUT);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_mode;
  logic                 r_signed;
  logic [2:0]           r_nlane;
  logic [15:0]          r_idle;
  logic [8:0]           r_a;
  logic [8:0]           r_b;
  logic [3:0]           r_mask;
  logic [4*TAG_W-1:0]   r_tags;
  logic [2:0]           r_half;
  logic                 r_out_valid;
  logic [1:0]           r_out_mode;
  logic                 r_out_signed;
  logic [3:0]           r_out_mask;
  logic [17:0]          r_out_c;
  logic [4*TAG_W-1:0]   r_out_tags;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_key_match;
  logic                 w_full;
  logic                 w_timeout;
  logic [1:0]           w_lane;
  logic [8:0]           w_a_lane;
  logic [8:0]           w_b_lane;
  logic [15:0]          w_idle_inc;

  // Position one request's operand inside the shared 9-bit multiplier input.
  function automatic logic [8:0] place(input logic [1:0] mode, input logic [1:0] lane,
                                       input logic [8:0] v);
    logic [8:0] p;
    p = '0;
    case (mode)
      2'd0: p = v;
      2'd1: begin
        if (lane[0]) p[8:5] = v[3:0];
        else         p[3:0] = v[3:0];
      end
      2'd2: begin
        case (lane)
          2'd0:    p[1:0] = v[1:0];
          2'd1:    p[3:2] = v[1:0];
          2'd2:    p[6:5] = v[1:0];
          default: p[8:7] = v[1:0];
        endcase
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  assign w_key_match = (in_mode == r_mode) && (in_signed == r_signed) && (in_mode != 2'd3);
  assign w_accept    = in_valid && w_ready;
  assign w_lane      = (r_state == S_FILL) ? r_nlane[1:0] : 2'd0;
  assign w_a_lane    = place(in_mode, w_lane, in_a);
  assign w_b_lane    = place(in_mode, w_lane, in_b);
  assign w_full      = (r_mode == 2'd1) ? (r_nlane == 3'd1) : (r_nlane == 3'd3);
  assign w_idle_inc  = r_idle + 16'd1;
  assign w_timeout   = (LP_FLUSH != 16'd0) && (w_idle_inc == LP_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (in_mode != 2'd3))
          w_next = (in_mode == 2'd0) ? S_ISSUE : S_FILL;
      end
      S_FILL: begin
        if (w_accept) begin
          if (w_full) w_next = S_ISSUE;
        end else if (in_valid || w_timeout) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A mismatching request is refused in FILL and picked up again from IDLE.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_FILL:  w_ready = in_valid ? w_key_match : 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode       <= 2'd0;
      r_signed     <= 1'b0;
      r_nlane      <= 3'd0;
      r_idle       <= 16'd0;
      r_a          <= 9'd0;
      r_b          <= 9'd0;
      r_mask       <= 4'd0;
      r_tags       <= '0;
      r_half       <= 3'b001;
      r_out_valid  <= 1'b0;
      r_out_mode   <= 2'd0;
      r_out_signed <= 1'b0;
      r_out_mask   <= 4'd0;
      r_out_c      <= 18'd0;
      r_out_tags   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (in_mode == 2'd3) begin
              r_err <= 1'b1;
            end else begin
              r_mode   <= in_mode;
              r_signed <= in_signed;
              r_a      <= w_a_lane;
              r_b      <= w_b_lane;
              r_mask   <= 4'b0001;
              r_tags   <= {{(3*TAG_W){1'b0}}, in_tag};
              r_nlane  <= 3'd1;
              r_idle   <= 16'd0;
              r_half   <= (in_mode == 2'd1) ? 3'b010 :
                          (in_mode == 2'd2) ? 3'b100 : 3'b001;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_a                           <= r_a | w_a_lane;
            r_b                           <= r_b | w_b_lane;
            r_mask[w_lane]                <= 1'b1;
            r_tags[w_lane*TAG_W +: TAG_W] <= in_tag;
            r_nlane                       <= r_nlane + 3'd1;
            r_idle                        <= 16'd0;
          end else if (!in_valid) begin
            r_idle <= w_idle_inc;
          end
        end
        S_ISSUE: begin
          r_out_c      <= mul_C;
          r_out_mode   <= r_mode;
          r_out_signed <= r_signed;
          r_out_mask   <= r_mask;
          r_out_tags   <= r_tags;
          r_out_valid  <= 1'b1;
        end
        default: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = w_ready;
  assign mul_A         = r_a;
  assign mul_B         = r_b;
  assign mul_A_sign    = r_signed;
  assign mul_B_sign    = r_signed;
  assign mul_HALF_0    = r_half[0];
  assign mul_HALF_1    = r_half[1];
  assign mul_HALF_2    = r_half[2];
  assign out_valid     = r_out_valid;
  assign out_mode      = r_out_mode;
  assign out_signed    = r_out_signed;
  assign out_lane_mask = r_out_mask;
  assign out_c         = r_out_c;
  assign out_tags      = r_out_tags;
  assign err_illegal   = r_err;

`ifdef MUL_SCHED_PERF_EN
  logic [31:0] r_perf_batches;
  logic [31:0] r_perf_lanes;
  logic [2:0]  w_pop;

  assign w_pop = {2'b00, r_mask[0]} + {2'b00, r_mask[1]} + {2'b00, r_mask[2]} + {2'b00, r_mask[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_batches <= 32'd0;
      r_perf_lanes   <= 32'd0;
    end else if (r_state == S_ISSUE) begin
      r_perf_batches <= r_perf_batches + 32'd1;
      r_perf_lanes   <= r_perf_lanes + {29'd0, w_pop};
    end
  end

  assign perf_batches = r_perf_batches;
  assign perf_lanes   = r_perf_lanes;
`endif

endmodule

// File: tb/tb_mul_frag_scheduler.sv
// tb/tb_mul_frag_scheduler.sv - randomized and directed bench for mul_frag_scheduler with a batch-level model
module tb_mul_frag_scheduler;
  localparam int TAG_W = 4;
  localparam int FT    = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic               in_signed;
  logic [8:0]         in_a;
  logic [8:0]         in_b;
  logic [TAG_W-1:0]   in_tag;
  logic [8:0]         mul_A;
  logic [8:0]         mul_B;
  logic               mul_A_sign;
  logic               mul_B_sign;
  logic               mul_HALF_0;
  logic               mul_HALF_1;
  logic               mul_HALF_2;
  logic [17:0]        mul_C;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_mode;
  logic               out_signed;
  logic [3:0]         out_lane_mask;
  logic [17:0]        out_c;
  logic [4*TAG_W-1:0] out_tags;
  logic               err_illegal;

  mul_frag_scheduler #(.TAG_W(TAG_W), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_A(mul_A), .mul_B(mul_B), .mul_A_sign(mul_A_sign), .mul_B_sign(mul_B_sign),
    .mul_HALF_0(mul_HALF_0), .mul_HALF_1(mul_HALF_1), .mul_HALF_2(mul_HALF_2),
    .mul_C(mul_C),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_signed(out_signed),
    .out_lane_mask(out_lane_mask), .out_c(out_c), .out_tags(out_tags), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Product of the low w bits of a and b, two's complement when s, kept to 2w bits.
  function automatic logic [17:0] prod(input logic [8:0] a, input logic [8:0] b, input int w, input logic s);
    longint x, y, m;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (s && (((x >> (w - 1)) & 1) == 1)) x = x - (longint'(1) << w);
    if (s && (((y >> (w - 1)) & 1) == 1)) y = y - (longint'(1) << w);
    return 18'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Fragmentable multiplier stand-in.
  always_comb begin
    mul_C = '0;
    if (mul_HALF_0)
      mul_C = prod(mul_A, mul_B, 9, mul_A_sign);
    else if (mul_HALF_1)
      mul_C = prod({5'd0, mul_A[3:0]}, {5'd0, mul_B[3:0]}, 4, mul_A_sign)
            | (prod({5'd0, mul_A[8:5]}, {5'd0, mul_B[8:5]}, 4, mul_A_sign) << 10);
    else if (mul_HALF_2)
      mul_C = prod({7'd0, mul_A[1:0]}, {7'd0, mul_B[1:0]}, 2, mul_A_sign)
            | (prod({7'd0, mul_A[3:2]}, {7'd0, mul_B[3:2]}, 2, mul_A_sign) << 4)
            | (prod({7'd0, mul_A[6:5]}, {7'd0, mul_B[6:5]}, 2, mul_A_sign) << 10)
            | (prod({7'd0, mul_A[8:7]}, {7'd0, mul_B[8:7]}, 2, mul_A_sign) << 14);
  end

  typedef struct {
    logic [1:0]       mode;
    logic             sgn;
    logic [8:0]       a;
    logic [8:0]       b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [17:0]        c;
    logic [3:0]         mask;
    logic [4*TAG_W-1:0] tags;
    logic [1:0]         mode;
    logic               sgn;
    int                 cyc;
  } cap_t;

  req_t m_lanes[$];
  req_t m_r;
  bit   m_acc;
  bit   m_closing = 0;
  bit   m_valid   = 0;
  bit   m_err     = 0;
  int   m_idle    = 0;
  logic [1:0]         m_half = 2'd0;
  logic [17:0]        e_c;
  logic [8:0]         e_A;
  logic [8:0]         e_B;
  logic [3:0]         e_mask;
  logic [4*TAG_W-1:0] e_tags;
  logic [1:0]         e_mode;
  logic               e_sgn;
  cap_t cap_q[$];

  function automatic int lane_w(input logic [1:0] md);
    return (md == 2'd0) ? 9 : (md == 2'd1) ? 4 : 2;
  endfunction

  function automatic int a_off(input logic [1:0] md, input int i);
    int t2[4] = '{0, 2, 5, 7};
    if (md == 2'd1) return i * 5;
    if (md == 2'd2) return t2[i];
    return 0;
  endfunction

  function automatic int c_off(input logic [1:0] md, input int i);
    int t2[4] = '{0, 4, 10, 14};
    if (md == 2'd1) return i * 10;
    if (md == 2'd2) return t2[i];
    return 0;
  endfunction

  function automatic void pack_batch();
    int w;
    e_c = '0; e_A = '0; e_B = '0; e_mask = '0; e_tags = '0;
    e_mode = m_lanes[0].mode;
    e_sgn  = m_lanes[0].sgn;
    w = lane_w(e_mode);
    foreach (m_lanes[i]) begin
      e_c = e_c | (prod(m_lanes[i].a, m_lanes[i].b, w, e_sgn) << c_off(e_mode, i));
      e_A = e_A | 9'((int'(m_lanes[i].a) & ((1 << w) - 1)) << a_off(e_mode, i));
      e_B = e_B | 9'((int'(m_lanes[i].b) & ((1 << w) - 1)) << a_off(e_mode, i));
      e_mask[i] = 1'b1;
      e_tags[i*TAG_W +: TAG_W] = m_lanes[i].tag;
    end
  endfunction

  function automatic bit exp_ready_f();
    if (m_closing || m_valid) return 1'b0;
    if (m_lanes.size() == 0) return 1'b1;
    if (!in_valid) return 1'b1;
    return (in_mode == m_lanes[0].mode) && (in_signed == m_lanes[0].sgn);
  endfunction

  // Batch lifecycle model: open lanes -> closing (issue cycle) -> result held.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_lanes.delete();
      m_closing = 0; m_valid = 0; m_err = 0; m_idle = 0; m_half = 2'd0;
    end else begin
      m_acc = in_valid && exp_ready_f();
      m_r   = '{in_mode, in_signed, in_a, in_b, in_tag};
      m_err = 0;
      if (m_closing) begin
        m_closing = 0;
        m_valid   = 1;
        m_lanes.delete();
      end else if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else if (m_lanes.size() == 0) begin
        if (m_acc) begin
          if (m_r.mode == 2'd3) m_err = 1;
          else begin
            m_lanes.push_back(m_r);
            m_half = m_r.mode;
            m_idle = 0;
            if (m_r.mode == 2'd0) begin m_closing = 1; pack_batch(); end
          end
        end
      end else begin
        if (m_acc) begin
          m_lanes.push_back(m_r);
          m_idle = 0;
          if (m_lanes.size() == ((m_r.mode == 2'd1) ? 2 : 4)) begin m_closing = 1; pack_batch(); end
        end else if (in_valid) begin
          m_closing = 1; pack_batch();
        end else begin
          m_idle++;
          if (FT != 0 && m_idle == FT) begin m_closing = 1; pack_batch(); end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", in_ready, exp_ready_f());
    chk("out_valid", out_valid, m_valid);
    chk("err_illegal", err_illegal, m_err);
    chk("half", {mul_HALF_2, mul_HALF_1, mul_HALF_0},
        (m_half == 2'd1) ? 3'b010 : (m_half == 2'd2) ? 3'b100 : 3'b001);
    if (m_valid) begin
      chk("out_c", out_c, e_c);
      chk("out_mask", out_lane_mask, e_mask);
      chk("out_tags", out_tags, e_tags);
      chk("out_mode", out_mode, e_mode);
      chk("out_signed", out_signed, e_sgn);
    end
    if (m_closing) begin
      chk("mul_A", mul_A, e_A);
      chk("mul_B", mul_B, e_B);
      chk("mul_sign", {mul_A_sign, mul_B_sign}, {e_sgn, e_sgn});
    end
  end

  initial forever begin
    @(negedge clk);
    if (out_valid && out_ready)
      cap_q.push_back('{out_c, out_lane_mask, out_tags, out_mode, out_signed, cyc});
  end

  task automatic send(input logic [1:0] md, input logic sg, input logic [8:0] a, input logic [8:0] b,
                      input logic [TAG_W-1:0] tg, output int stalls);
    stalls = 0;
    in_valid = 1'b1; in_mode = md; in_signed = sg; in_a = a; in_b = b; in_tag = tg;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 100) begin chk("send_timeout", 1, 0); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output cap_t r);
    int n = 0;
    r = '{18'd0, 4'd0, '0, 2'd0, 1'b0, 0};
    while (cap_q.size() == 0 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (cap_q.size() == 0) chk("result_timeout", 1, 0);
    else r = cap_q.pop_front();
  endtask

  initial begin
    cap_t r;
    int   st;
    logic [1:0] key_mode;
    logic       key_sgn;
    int   sel;

    reset = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_mul_A", mul_A, 0);
    chk("rst_half", {mul_HALF_2, mul_HALF_1, mul_HALF_0}, 3'b001);
    chk("rst_tags", out_tags, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 9-bit unsigned 300*200
    send(2'd0, 1'b0, 9'd300, 9'd200, 4'd3, st);
    wait_res(r);
    chk("t1_c", r.c, 18'd60000);
    chk("t1_mask", r.mask, 4'b0001);
    chk("t1_tags", r.tags, 16'h0003);
    chk("t1_lat", r.cyc - last_acc_cyc + 1, 2);
    chk("t1_half0", mul_HALF_0, 1);
    @(posedge clk); #1;

    // signed 4-bit (-3,5),(7,-2)
    send(2'd1, 1'b1, 9'h00D, 9'h005, 4'd1, st);
    send(2'd1, 1'b1, 9'h007, 9'h00E, 4'd2, st);
    wait_res(r);
    chk("t2_c", r.c, 18'h3C8F1);
    chk("t2_mask", r.mask, 4'b0011);
    chk("t2_tags", r.tags, 16'h0021);
    chk("t2_half1", mul_HALF_1, 1);
    @(posedge clk); #1;

    // unsigned 2-bit, four lanes
    send(2'd2, 1'b0, 9'd3, 9'd3, 4'd1, st);
    send(2'd2, 1'b0, 9'd2, 9'd1, 4'd2, st);
    send(2'd2, 1'b0, 9'd1, 9'd1, 4'd3, st);
    send(2'd2, 1'b0, 9'd3, 9'd2, 4'd4, st);
    wait_res(r);
    chk("t3_c", r.c, 18'h18429);
    chk("t3_mask", r.mask, 4'b1111);
    chk("t3_tags", r.tags, 16'h4321);
    chk("t3_mulA", mul_A, 9'h1AB);
    chk("t3_mulB", mul_B, 9'h127);
    @(posedge clk); #1;

    // lone 4-bit request flushed by timeout
    send(2'd1, 1'b0, 9'd5, 9'd6, 4'd7, st);
    wait_res(r);
    chk("t4_c", r.c, 18'd30);
    chk("t4_mask", r.mask, 4'b0001);
    chk("t4_lat", r.cyc - last_acc_cyc + 1, FT + 2);
    chk("t4_mulA", mul_A, 9'h005);
    @(posedge clk); #1;

    // key change forces early issue
    send(2'd2, 1'b0, 9'd1, 9'd1, 4'd1, st);
    send(2'd2, 1'b1, 9'd3, 9'd1, 4'd2, st);
    chk("t5_stalled", (st > 0), 1);
    wait_res(r);
    chk("t5a_c", r.c, 18'd1);
    chk("t5a_mask", r.mask, 4'b0001);
    wait_res(r);
    chk("t5b_c", r.c, 18'h0000F);
    chk("t5b_sgn", r.sgn, 1);
    @(posedge clk); #1;

    // back-pressure holds the result
    out_ready = 1'b0;
    send(2'd0, 1'b1, 9'h1FB, 9'h007, 4'd4, st);
    st = 0;
    while (!out_valid && st < 50) begin @(negedge clk); st++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", out_valid, 1);
      chk("t6_hold_c", out_c, 18'h3FFDD);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_res(r);
    chk("t6_c", r.c, 18'h3FFDD);
    @(posedge clk); #1;

    // illegal mode
    send(2'd3, 1'b0, 9'd1, 9'd1, 4'd5, st);
    @(negedge clk);
    chk("t7_err", err_illegal, 1);
    @(negedge clk);
    chk("t7_err_clr", err_illegal, 0);
    repeat (5) @(negedge clk);
    chk("t7_no_issue", cap_q.size(), 0);
    @(posedge clk); #1;

    // reset while a batch is filling
    send(2'd2, 1'b0, 9'd1, 9'd1, 4'd9, st);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t8_valid", out_valid, 0);
    @(posedge clk); #1;
    send(2'd2, 1'b0, 9'd1, 9'd2, 4'd5, st);
    send(2'd2, 1'b0, 9'd2, 9'd2, 4'd6, st);
    send(2'd2, 1'b0, 9'd3, 9'd3, 4'd7, st);
    send(2'd2, 1'b0, 9'd0, 9'd1, 4'd8, st);
    wait_res(r);
    chk("t8_c", r.c, 18'h02442);
    chk("t8_tags", r.tags, 16'h8765);
    chk("t8_mask", r.mask, 4'b1111);
    @(posedge clk); #1;

    // randomized traffic
    key_mode = 2'd1; key_sgn = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        sel = $urandom_range(0, 9);
        key_mode = (sel == 0) ? 2'd0 : (sel <= 4) ? 2'd1 : (sel <= 8) ? 2'd2 : 2'd3;
        key_sgn  = 1'($urandom_range(0, 1));
      end
      if ((c % 400) > 300) in_valid = ($urandom_range(0, 11) == 0);
      else                 in_valid = ($urandom_range(0, 3) != 0);
      in_mode   = key_mode;
      in_signed = key_sgn;
      in_a      = 9'($urandom);
      in_b      = 9'($urandom);
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
